// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared encodings for the data-memory arbiter: arbiter state,
//                read-return owner and the I/O region address bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Arbiter state: open arbitration or DMA burst ownership
  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // Which requester a pending read belongs to
  typedef enum logic [0:0] {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  // Byte-address bit that selects the memory-mapped I/O region
  localparam int IO_REGION_BIT = 31;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_starve_counter
//  Description : Saturating count of consecutive cycles the DMA port was
//                denied. at_limit_o tells the arbiter to force a DMA win.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter_starve_counter #(
  parameter int CNT_BITS     = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [CNT_BITS-1:0] LIMIT = CNT_BITS'(STARVE_LIMIT);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  // Clear wins over increment; increment stops once the limit is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT);

endmodule : dmem_arbiter_starve_counter
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single-port, one-cycle-latency data memory between
//                the CPU load/store path and the DMA/debug-loader port. CPU has
//                priority, DMA gets a forced win after repeated denial, and DMA
//                can lock the memory for bursts. Read data returns to the
//                owner one cycle after the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int ADDR_BITS    = 11,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_BITS     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  // CPU port
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [DBITS-1:0]     cpu_addr,
  input  logic [DBITS-1:0]     cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [DBITS-1:0]     cpu_rdata,
  // DMA port
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic                 dma_lock,
  input  logic [DBITS-1:0]     dma_addr,
  input  logic [DBITS-1:0]     dma_wdata,
  output logic                 dma_gnt,
  output logic                 dma_rvalid,
  output logic [DBITS-1:0]     dma_rdata,
  // Memory port
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DBITS-1:0]     mem_wdata,
  output logic                 mem_we,
  input  logic [DBITS-1:0]     mem_rdata
);

  arb_state_e state_q;
  arb_state_e state_d;
  owner_e     rd_owner_q;
  owner_e     rd_owner_d;
  logic       rd_pending_q;
  logic       rd_pending_d;

  logic       w_cpu_win;
  logic       w_dma_win;
  logic       w_at_limit;
  logic       w_starve_inc;
  logic       w_starve_clr;

  // Only a few address bits reach the memory; fold the rest away explicitly
  logic       w_unused_addr_bits;
  assign w_unused_addr_bits = ^{cpu_addr, dma_addr};

  // Winner selection and next state; grants are held off while in reset
  always_comb begin
    w_cpu_win = 1'b0;
    w_dma_win = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      ST_ARB: begin
        if (cpu_req && !(dma_req && w_at_limit)) begin
          w_cpu_win = 1'b1;
        end else if (dma_req) begin
          w_dma_win = 1'b1;
        end
        if (w_dma_win && dma_lock) begin
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        w_dma_win = dma_req;
        if (!(dma_req && dma_lock)) begin
          state_d = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
    if (reset) begin
      w_cpu_win = 1'b0;
      w_dma_win = 1'b0;
    end
  end

  assign cpu_gnt = w_cpu_win;
  assign dma_gnt = w_dma_win;

  // Memory port driven by the winner; I/O-region writes never reach memory
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (w_cpu_win) begin
      mem_addr  = cpu_addr[ADDR_BITS+1:2];
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we & ~cpu_addr[IO_REGION_BIT];
    end else if (w_dma_win) begin
      mem_addr  = dma_addr[ADDR_BITS+1:2];
      mem_wdata = dma_wdata;
      mem_we    = dma_we & ~dma_addr[IO_REGION_BIT];
    end
  end

  // Remember which port's read is in flight; owner only changes on a read
  always_comb begin
    rd_pending_d = (w_cpu_win & ~cpu_we) | (w_dma_win & ~dma_we);
    rd_owner_d   = rd_owner_q;
    if (w_cpu_win && !cpu_we) begin
      rd_owner_d = OWNER_CPU;
    end else if (w_dma_win && !dma_we) begin
      rd_owner_d = OWNER_DMA;
    end
  end

  // State and read-tracking registers; reset drops any pending read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ARB;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= OWNER_CPU;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign cpu_rvalid = rd_pending_q && (rd_owner_q == OWNER_CPU);
  assign dma_rvalid = rd_pending_q && (rd_owner_q == OWNER_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

  // Starvation only accrues while arbitrating; a grant or idle DMA clears it
  assign w_starve_inc = dma_req & ~w_dma_win & (state_q == ST_ARB);
  assign w_starve_clr = ~dma_req | w_dma_win;

  dmem_arbiter_starve_counter #(
    .CNT_BITS     (CNT_BITS),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (w_starve_inc),
    .clr_i      (w_starve_clr),
    .at_limit_o (w_at_limit)
  );

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(
    .DBITS(32), .ADDR_BITS(11), .STARVE_LIMIT(4), .CNT_BITS(3)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word at index i reads back as A5A5A000 | i, one cycle later
  always @(posedge clk) mem_rdata <= {20'hA5A5A, 1'b0, mem_addr};

  function automatic logic [31:0] mem_word(input int idx);
    return {20'hA5A5A, 1'b0, 11'(idx)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
    dma_req = req; dma_we = we; dma_lock = lock; dma_addr = addr; dma_wdata = wdata;
  endtask

  task automatic idle();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    // Requests during reset must not produce grants or a memory write
    set_cpu(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    set_dma(1'b1, 1'b1, 1'b0, 32'hC, 32'h1);
    repeat (2) @(posedge clk);
    #3;
    check("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
    check("rst_dma_gnt",    32'(dma_gnt),    32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_state",      32'(dut.state_q), 32'(ST_ARB));
    check("rst_cnt",        32'(dut.u_starve.cnt_q), 32'd0);
    tick();
    reset = 1'b0;
    idle();

    // CPU read of byte 0x10
    tick();
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    #2;
    check("rd_cpu_gnt",  32'(cpu_gnt), 32'd1);
    check("rd_dma_gnt",  32'(dma_gnt), 32'd0);
    check("rd_mem_addr", 32'(mem_addr), 32'd4);
    check("rd_mem_we",   32'(mem_we), 32'd0);
    tick();
    idle();
    #2;
    check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("rd_cpu_rdata",  cpu_rdata, mem_word(4));
    check("rd_dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("rd_dma_rdata",  dma_rdata, 32'd0);
    check("rd_idle_addr",  32'(mem_addr), 32'd0);
    tick();
    #2;
    check("rd_rvalid_once", 32'(cpu_rvalid), 32'd0);

    // Continuous contention: CPU wins 4 cycles, DMA forced on the 5th
    for (int i = 0; i < 10; i++) begin
      tick();
      set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
      set_dma(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
      #2;
      check($sformatf("starve_cpu_gnt%0d", i), 32'(cpu_gnt), 32'((i % 5) != 4));
      check($sformatf("starve_dma_gnt%0d", i), 32'(dma_gnt), 32'((i % 5) == 4));
      check($sformatf("starve_cnt%0d", i), 32'(dut.u_starve.cnt_q), 32'(i % 5));
      if ((i % 5) == 4) check($sformatf("starve_addr%0d", i), 32'(mem_addr), 32'h20);
      if (i > 0) begin
        if (((i - 1) % 5) == 4) begin
          check($sformatf("starve_dma_rv%0d", i), 32'(dma_rvalid), 32'd1);
          check($sformatf("starve_dma_rd%0d", i), dma_rdata, mem_word(32'h20));
          check($sformatf("starve_cpu_rv%0d", i), 32'(cpu_rvalid), 32'd0);
        end else begin
          check($sformatf("starve_cpu_rv%0d", i), 32'(cpu_rvalid), 32'd1);
          check($sformatf("starve_cpu_rd%0d", i), cpu_rdata, mem_word(32'h10));
          check($sformatf("starve_dma_rv%0d", i), 32'(dma_rvalid), 32'd0);
        end
      end
    end
    tick();
    idle();
    #2;
    check("starve_last_dma_rv", 32'(dma_rvalid), 32'd1);
    check("starve_cnt_clear",   32'(dut.u_starve.cnt_q), 32'd0);
    tick();

    // Locked DMA write burst with CPU waiting throughout
    for (int c = 0; c < 9; c++) begin
      tick();
      set_cpu(1'b1, 1'b0, 32'h100, 32'h0);
      set_dma(c < 8, 1'b1, c < 7, 32'h20 + 32'(4 * ((c > 4) ? c - 4 : 0)),
              32'hD0 + 32'(c));
      #2;
      if (c < 4) begin
        check($sformatf("lock_pre_cpu_gnt%0d", c), 32'(cpu_gnt), 32'd1);
        check($sformatf("lock_pre_dma_gnt%0d", c), 32'(dma_gnt), 32'd0);
      end else if (c < 8) begin
        check($sformatf("lock_cpu_gnt%0d", c),  32'(cpu_gnt), 32'd0);
        check($sformatf("lock_dma_gnt%0d", c),  32'(dma_gnt), 32'd1);
        check($sformatf("lock_mem_addr%0d", c), 32'(mem_addr), 32'(8 + c - 4));
        check($sformatf("lock_mem_we%0d", c),   32'(mem_we), 32'd1);
        check($sformatf("lock_wdata%0d", c),    mem_wdata, 32'hD0 + 32'(c));
        if (c > 4) check($sformatf("lock_state%0d", c), 32'(dut.state_q), 32'(ST_LOCK));
      end else begin
        check("lock_cpu_resume", 32'(cpu_gnt), 32'd1);
        check("lock_dma_gnt_end", 32'(dma_gnt), 32'd0);
        check("lock_state_arb",  32'(dut.state_q), 32'(ST_ARB));
        check("lock_wr_no_rv",   32'(dma_rvalid), 32'd0);
      end
    end
    tick();
    idle();

    // CPU write to I/O region, then a normal memory write
    tick();
    set_cpu(1'b1, 1'b1, 32'hF000_0004, 32'h55AA_55AA);
    #2;
    check("io_cpu_gnt",  32'(cpu_gnt), 32'd1);
    check("io_mem_we",   32'(mem_we), 32'd0);
    check("io_mem_addr", 32'(mem_addr), 32'd1);
    tick();
    set_cpu(1'b1, 1'b1, 32'h8, 32'h1234_5678);
    #2;
    check("io_no_cpu_rv", 32'(cpu_rvalid), 32'd0);
    check("io_no_dma_rv", 32'(dma_rvalid), 32'd0);
    check("wr_mem_we",    32'(mem_we), 32'd1);
    check("wr_mem_addr",  32'(mem_addr), 32'd2);
    check("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    tick();
    idle();
    #2;
    check("wr_no_cpu_rv", 32'(cpu_rvalid), 32'd0);

    // Reset arrives while a locked DMA read is in flight
    tick();
    set_dma(1'b1, 1'b0, 1'b1, 32'h30, 32'h0);
    #2;
    check("rm_dma_gnt", 32'(dma_gnt), 32'd1);
    tick();
    reset = 1'b1;
    #2;
    check("rm_dma_rv_rst", 32'(dma_rvalid), 32'd0);
    check("rm_dma_gnt_rst", 32'(dma_gnt), 32'd0);
    check("rm_cpu_gnt_rst", 32'(cpu_gnt), 32'd0);
    check("rm_state_rst",   32'(dut.state_q), 32'(ST_ARB));
    tick();
    reset = 1'b0;
    idle();
    #2;
    check("rm_dma_rv_after", 32'(dma_rvalid), 32'd0);
    check("rm_state_after",  32'(dut.state_q), 32'(ST_ARB));
    check("rm_cnt_after",    32'(dut.u_starve.cnt_q), 32'd0);

    // Alternating CPU / DMA reads on consecutive cycles
    for (int c = 0; c < 5; c++) begin
      tick();
      idle();
      if (c < 4) begin
        if ((c % 2) == 0) set_cpu(1'b1, 1'b0, 32'h44 + 32'(4 * c), 32'h0);
        else              set_dma(1'b1, 1'b0, 1'b0, 32'h44 + 32'(4 * c), 32'h0);
      end
      #2;
      if (c < 4) begin
        check($sformatf("alt_cpu_gnt%0d", c), 32'(cpu_gnt), 32'((c % 2) == 0));
        check($sformatf("alt_dma_gnt%0d", c), 32'(dma_gnt), 32'((c % 2) == 1));
      end
      if (c > 0) begin
        if (((c - 1) % 2) == 0) begin
          check($sformatf("alt_cpu_rv%0d", c), 32'(cpu_rvalid), 32'd1);
          check($sformatf("alt_cpu_rd%0d", c), cpu_rdata, mem_word(17 + c - 1));
          check($sformatf("alt_dma_rv%0d", c), 32'(dma_rvalid), 32'd0);
          check($sformatf("alt_dma_rd%0d", c), dma_rdata, 32'd0);
        end else begin
          check($sformatf("alt_dma_rv%0d", c), 32'(dma_rvalid), 32'd1);
          check($sformatf("alt_dma_rd%0d", c), dma_rdata, mem_word(17 + c - 1));
          check($sformatf("alt_cpu_rv%0d", c), 32'(cpu_rvalid), 32'd0);
          check($sformatf("alt_cpu_rd%0d", c), cpu_rdata, 32'd0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
